// File: rtl/pred_fetch_unit_pkg.sv
// Shared constants and helpers for the predicting fetch front end.
// Entry and IF/ID record layouts depend on module parameters, so they are typedef'd in the modules.
package pred_fetch_unit_pkg;

    localparam logic [1:0] CTR_STRONG_NOT   = 2'b00;
    localparam logic [1:0] CTR_WEAK_TAKEN   = 2'b10;
    localparam logic [1:0] CTR_STRONG_TAKEN = 2'b11;
    localparam int         PC_INC           = 4;

    // 2-bit saturating predictor step
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_STRONG_TAKEN) ? ctr : ctr + 2'd1;
        end
        return (ctr == CTR_STRONG_NOT) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/pred_fetch_unit_btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters.
// Lookup is combinational on the fetch PC and always sees pre-update contents.
module btb_predictor
    import pred_fetch_unit_pkg::*;
#(
    parameter int PC_W      = 9,
    parameter int BTB_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = PC_W - IDX_W - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [1:0]       ctr;
    } btb_entry_t;

    btb_entry_t entry_reg [BTB_DEPTH];

    logic [IDX_W-1:0] lk_idx;
    btb_entry_t       lk_entry;
    logic             lk_hit;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    btb_entry_t       upd_cur;
    logic             upd_hit;
    logic             upd_we;
    btb_entry_t       entry_next;

    // Instructions are word aligned; the byte offset never reaches the table.
    logic unused_lsbs;
    assign unused_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx      = lookup_pc[IDX_W+1:2];
    assign lk_entry    = entry_reg[lk_idx];
    assign lk_hit      = lk_entry.valid && (lk_entry.tag == lookup_pc[PC_W-1:IDX_W+2]);
    assign pred_taken  = lk_hit && lk_entry.ctr[1];
    assign pred_target = lk_entry.target;

    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[PC_W-1:IDX_W+2];
    assign upd_cur = entry_reg[upd_idx];
    assign upd_hit = upd_cur.valid && (upd_cur.tag == upd_tag);

    always_comb begin
        entry_next = upd_cur;
        upd_we     = 1'b0;
        if (upd_valid) begin
            if (upd_hit) begin
                upd_we         = 1'b1;
                entry_next.ctr = ctr_update(upd_cur.ctr, upd_taken);
                if (upd_taken) begin
                    entry_next.target = upd_target;
                end
            end else if (upd_taken) begin
                // Miss on a taken branch: allocate, evicting any alias.
                upd_we            = 1'b1;
                entry_next.valid  = 1'b1;
                entry_next.tag    = upd_tag;
                entry_next.target = upd_target;
                entry_next.ctr    = CTR_WEAK_TAKEN;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < BTB_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset) begin
                    entry_reg[gi].valid <= 1'b0;
                    entry_reg[gi].ctr   <= CTR_STRONG_NOT;
                end else if (upd_we && (upd_idx == IDX_W'(gi))) begin
                    entry_reg[gi] <= entry_next;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pred_fetch_unit.sv
// Fetch front end: PC register, predicted next-PC selection, IF/ID register
// and a saturating count of EX redirects.
module pred_fetch_unit
    import pred_fetch_unit_pkg::*;
#(
    parameter int              PC_W      = 9,
    parameter int              INS_W     = 32,
    parameter int              BTB_DEPTH = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [PC_W-1:0]  redirect_pc_i,
    input  logic             upd_valid_i,
    input  logic [PC_W-1:0]  upd_pc_i,
    input  logic             upd_taken_i,
    input  logic [PC_W-1:0]  upd_target_i,
    output logic [PC_W-1:0]  imem_addr_o,
    input  logic [INS_W-1:0] imem_instr_i,
    output logic             if_valid_o,
    output logic [PC_W-1:0]  if_pc_o,
    output logic [INS_W-1:0] if_instr_o,
    output logic             if_pred_taken_o,
    output logic [PC_W-1:0]  if_pred_target_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    typedef struct packed {
        logic             valid;
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] instr;
        logic             pred_taken;
        logic [PC_W-1:0]  pred_target;
    } if_id_pred_reg;

    logic [PC_W-1:0]  pc_reg;
    logic [PC_W-1:0]  pc_next;
    if_id_pred_reg    ifid_reg;
    if_id_pred_reg    ifid_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;

    btb_predictor #(
        .PC_W      (PC_W),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk         (clk),
        .reset       (reset),
        .lookup_pc   (pc_reg),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid_i),
        .upd_pc      (upd_pc_i),
        .upd_taken   (upd_taken_i),
        .upd_target  (upd_target_i)
    );

    // Redirect outranks stall so a mispredict is never lost behind a load-use hold.
    always_comb begin
        if (redirect_i) begin
            pc_next = redirect_pc_i;
        end else if (stall_i) begin
            pc_next = pc_reg;
        end else if (pred_taken) begin
            pc_next = pred_target;
        end else begin
            pc_next = pc_reg + PC_W'(PC_INC);
        end
    end

    always_comb begin
        ifid_next = ifid_reg;
        if (redirect_i) begin
            ifid_next = '0;
        end else if (!stall_i) begin
            ifid_next.valid       = 1'b1;
            ifid_next.pc          = pc_reg;
            ifid_next.instr       = imem_instr_i;
            ifid_next.pred_taken  = pred_taken;
            ifid_next.pred_target = pred_taken ? pred_target : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg   <= RESET_PC;
            ifid_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            pc_reg   <= pc_next;
            ifid_reg <= ifid_next;
            if (redirect_i && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign imem_addr_o      = pc_reg;
    assign if_valid_o       = ifid_reg.valid;
    assign if_pc_o          = ifid_reg.pc;
    assign if_instr_o       = ifid_reg.instr;
    assign if_pred_taken_o  = ifid_reg.pred_taken;
    assign if_pred_target_o = ifid_reg.pred_target;
    assign mispredict_cnt_o = cnt_reg;

endmodule

// File: tb/tb_pred_fetch_unit.sv
// Scenario tasks plus a randomized run, all checked against an array-based model of the fetch unit.
module tb_pred_fetch_unit;

    localparam int PC_W    = 9;
    localparam int INS_W   = 32;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = 4;
    localparam int PC_MOD  = 512;
    localparam int CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall_i;
    logic             redirect_i;
    logic [PC_W-1:0]  redirect_pc_i;
    logic             upd_valid_i;
    logic [PC_W-1:0]  upd_pc_i;
    logic             upd_taken_i;
    logic [PC_W-1:0]  upd_target_i;
    logic [PC_W-1:0]  imem_addr_o;
    logic [INS_W-1:0] imem_instr_i;
    logic             if_valid_o;
    logic [PC_W-1:0]  if_pc_o;
    logic [INS_W-1:0] if_instr_o;
    logic             if_pred_taken_o;
    logic [PC_W-1:0]  if_pred_target_o;
    logic [CNT_W-1:0] mispredict_cnt_o;

    always #5 clk = ~clk;

    pred_fetch_unit #(
        .PC_W      (PC_W),
        .INS_W     (INS_W),
        .BTB_DEPTH (DEPTH),
        .RESET_PC  ('0),
        .CNT_W     (CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_i          (stall_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
        .imem_addr_o      (imem_addr_o),
        .imem_instr_i     (imem_instr_i),
        .if_valid_o       (if_valid_o),
        .if_pc_o          (if_pc_o),
        .if_instr_o       (if_instr_o),
        .if_pred_taken_o  (if_pred_taken_o),
        .if_pred_target_o (if_pred_target_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    function automatic logic [INS_W-1:0] instr_of(input logic [PC_W-1:0] a);
        return {7'h5A, a, 7'h33, a};
    endfunction

    assign imem_instr_i = instr_of(imem_addr_o);

    // Reference model state
    int               m_pc;
    bit               m_v   [DEPTH];
    int               m_tag [DEPTH];
    int               m_tgt [DEPTH];
    int               m_ctr [DEPTH];
    bit               m_if_valid;
    int               m_if_pc;
    logic [INS_W-1:0] m_if_instr;
    bit               m_if_ptk;
    int               m_if_ptgt;
    int               m_cnt;

    int vectors    = 0;
    int miscompares = 0;

    function automatic logic [64:0] obs();
        return {if_valid_o, if_pc_o, if_instr_o, if_pred_taken_o, if_pred_target_o,
                mispredict_cnt_o, imem_addr_o};
    endfunction

    function automatic logic [64:0] expv();
        return {m_if_valid, 9'(m_if_pc), m_if_instr, m_if_ptk, 9'(m_if_ptgt),
                4'(m_cnt), 9'(m_pc)};
    endfunction

    task automatic idle();
        reset         = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        upd_valid_i   = 1'b0;
        upd_pc_i      = '0;
        upd_taken_i   = 1'b0;
        upd_target_i  = '0;
    endtask

    // One clock: predict from model state, advance the model at the edge, return at negedge.
    task automatic cycle();
        int idx, tg, ptgt, ui, ut, upc;
        bit ptk;
        idx  = (m_pc / 4) % DEPTH;
        tg   = m_pc / (4 * DEPTH);
        ptk  = m_v[idx] && (m_tag[idx] == tg) && (m_ctr[idx] >= 2);
        ptgt = m_tgt[idx];
        @(posedge clk);
        if (reset) begin
            m_pc = 0;
            m_if_valid = 0; m_if_pc = 0; m_if_instr = '0; m_if_ptk = 0; m_if_ptgt = 0;
            m_cnt = 0;
            for (int i = 0; i < DEPTH; i++) begin
                m_v[i] = 0;
                m_ctr[i] = 0;
            end
        end else begin
            if (redirect_i) begin
                m_if_valid = 0; m_if_pc = 0; m_if_instr = '0; m_if_ptk = 0; m_if_ptgt = 0;
                if (m_cnt < CNT_MAX) m_cnt++;
            end else if (!stall_i) begin
                m_if_valid = 1;
                m_if_pc    = m_pc;
                m_if_instr = instr_of(9'(m_pc));
                m_if_ptk   = ptk;
                m_if_ptgt  = ptk ? ptgt : 0;
            end
            if (redirect_i)    m_pc = int'(redirect_pc_i);
            else if (stall_i)  m_pc = m_pc;
            else if (ptk)      m_pc = ptgt;
            else               m_pc = (m_pc + 4) % PC_MOD;
            if (upd_valid_i) begin
                upc = int'(upd_pc_i);
                ui  = (upc / 4) % DEPTH;
                ut  = upc / (4 * DEPTH);
                if (m_v[ui] && m_tag[ui] == ut) begin
                    if (upd_taken_i) begin
                        if (m_ctr[ui] < 3) m_ctr[ui]++;
                        m_tgt[ui] = int'(upd_target_i);
                    end else if (m_ctr[ui] > 0) begin
                        m_ctr[ui]--;
                    end
                end else if (upd_taken_i) begin
                    m_v[ui]   = 1;
                    m_tag[ui] = ut;
                    m_tgt[ui] = int'(upd_target_i);
                    m_ctr[ui] = 2;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic jump_to(input int pc);
        idle();
        redirect_i    = 1'b1;
        redirect_pc_i = 9'(pc);
        cycle();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        cycle();
        cycle();
        vectors++;
        if (obs() !== 65'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h exp %h", obs(), 65'd0);
        end
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            vectors++;
            if (imem_addr_o !== 9'(4 * k) || if_valid_o !== 1'b1 || if_pred_taken_o !== 1'b0
                || obs() !== expv()) begin
                miscompares++;
                $display("FAIL free_run k=%0d: got %h exp %h", k, obs(), expv());
            end
        end
        $display("test_reset done: vectors=%0d", vectors);
    endtask

    task automatic test_btb_train();
        reset_pulse();
        upd_valid_i  = 1'b1;
        upd_pc_i     = 9'h010;
        upd_taken_i  = 1'b1;
        upd_target_i = 9'h040;
        cycle();
        idle();
        cycle();
        cycle();
        cycle();
        cycle();
        vectors++;
        if (if_pc_o !== 9'h010 || if_pred_taken_o !== 1'b1 || if_pred_target_o !== 9'h040
            || imem_addr_o !== 9'h040 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL btb_train: got %h exp %h", obs(), expv());
        end
        $display("test_btb_train done: pc=%h pred=%b", if_pc_o, if_pred_taken_o);
    endtask

    task automatic test_counter_decay();
        for (int i = 0; i < 3; i++) begin
            idle();
            upd_valid_i = 1'b1;
            upd_pc_i    = 9'h010;
            upd_taken_i = 1'b0;
            cycle();
        end
        jump_to(32'h010);
        cycle();
        vectors++;
        if (if_pc_o !== 9'h010 || if_pred_taken_o !== 1'b0 || imem_addr_o !== 9'h014
            || obs() !== expv()) begin
            miscompares++;
            $display("FAIL ctr_decay: got %h exp %h", obs(), expv());
        end
        // A fourth not-taken must hold at 0, so one taken only reaches weak-not-taken.
        upd_valid_i = 1'b1; upd_pc_i = 9'h010; upd_taken_i = 1'b0;
        cycle();
        upd_valid_i = 1'b1; upd_pc_i = 9'h010; upd_taken_i = 1'b1; upd_target_i = 9'h040;
        cycle();
        jump_to(32'h010);
        cycle();
        vectors++;
        if (if_pred_taken_o !== 1'b0 || imem_addr_o !== 9'h014 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL ctr_floor: got %h exp %h", obs(), expv());
        end
        $display("test_counter_decay done: addr=%h", imem_addr_o);
    endtask

    task automatic test_stall();
        logic [64:0] held;
        logic [PC_W-1:0] addr0;
        jump_to(32'h100);
        cycle();
        cycle();
        held  = obs();
        addr0 = imem_addr_o;
        stall_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cycle();
            vectors++;
            if (obs() !== held || obs() !== expv()) begin
                miscompares++;
                $display("FAIL stall_hold k=%0d: got %h exp %h", k, obs(), held);
            end
        end
        stall_i = 1'b0;
        cycle();
        vectors++;
        if (imem_addr_o !== addr0 + 9'd4 || if_pc_o !== addr0 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL stall_resume: got %h exp %h", obs(), expv());
        end
        $display("test_stall done: addr=%h", imem_addr_o);
    endtask

    task automatic test_redirect_stall();
        logic [CNT_W-1:0] cnt0;
        cnt0          = mispredict_cnt_o;
        stall_i       = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 9'h080;
        cycle();
        idle();
        vectors++;
        if (imem_addr_o !== 9'h080 || if_valid_o !== 1'b0 || mispredict_cnt_o !== cnt0 + 4'd1
            || obs() !== expv()) begin
            miscompares++;
            $display("FAIL redirect_stall: got %h exp %h", obs(), expv());
        end
        $display("test_redirect_stall done: cnt=%0d", mispredict_cnt_o);
    endtask

    task automatic test_alias();
        reset_pulse();
        upd_valid_i = 1'b1; upd_pc_i = 9'h010; upd_taken_i = 1'b1; upd_target_i = 9'h040;
        cycle();
        upd_valid_i = 1'b1; upd_pc_i = 9'h050; upd_taken_i = 1'b1; upd_target_i = 9'h060;
        cycle();
        jump_to(32'h010);
        cycle();
        vectors++;
        if (if_pc_o !== 9'h010 || if_pred_taken_o !== 1'b0 || imem_addr_o !== 9'h014
            || obs() !== expv()) begin
            miscompares++;
            $display("FAIL alias_evict: got %h exp %h", obs(), expv());
        end
        jump_to(32'h050);
        cycle();
        vectors++;
        if (if_pc_o !== 9'h050 || if_pred_taken_o !== 1'b1 || if_pred_target_o !== 9'h060
            || imem_addr_o !== 9'h060 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL alias_hit: got %h exp %h", obs(), expv());
        end
        // Freshly allocated entry is weak-taken: one not-taken flips it.
        upd_valid_i = 1'b1; upd_pc_i = 9'h050; upd_taken_i = 1'b0;
        cycle();
        jump_to(32'h050);
        cycle();
        vectors++;
        if (if_pred_taken_o !== 1'b0 || imem_addr_o !== 9'h054 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL alloc_weak: got %h exp %h", obs(), expv());
        end
        upd_valid_i = 1'b1; upd_pc_i = 9'h050; upd_taken_i = 1'b1; upd_target_i = 9'h060;
        cycle();
        idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        vectors++;
        if (obs() !== 65'd0 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL midrun_reset: got %h exp %h", obs(), 65'd0);
        end
        jump_to(32'h050);
        cycle();
        vectors++;
        if (if_pred_taken_o !== 1'b0 || imem_addr_o !== 9'h054 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL reset_clears_btb: got %h exp %h", obs(), expv());
        end
        $display("test_alias done: addr=%h", imem_addr_o);
    endtask

    task automatic test_wrap_saturate();
        reset_pulse();
        jump_to(32'h1FC);
        cycle();
        vectors++;
        if (imem_addr_o !== 9'h000 || if_pc_o !== 9'h1FC || obs() !== expv()) begin
            miscompares++;
            $display("FAIL pc_wrap: got %h exp %h", obs(), expv());
        end
        redirect_i    = 1'b1;
        redirect_pc_i = 9'h020;
        for (int k = 0; k < 20; k++) cycle();
        idle();
        vectors++;
        if (mispredict_cnt_o !== 4'hF || obs() !== expv()) begin
            miscompares++;
            $display("FAIL cnt_saturate: got %h exp %h", obs(), expv());
        end
        $display("test_wrap_saturate done: cnt=%0d", mispredict_cnt_o);
    endtask

    task automatic test_random();
        reset_pulse();
        for (int n = 0; n < 600; n++) begin
            idle();
            reset         = ($urandom_range(0, 63) == 0);
            stall_i       = ($urandom_range(0, 5) == 0);
            redirect_i    = ($urandom_range(0, 9) == 0);
            redirect_pc_i = 9'($urandom_range(0, 127) * 4);
            upd_valid_i   = ($urandom_range(0, 2) == 0);
            upd_pc_i      = ($urandom_range(0, 1) == 0) ? 9'(m_pc) : 9'($urandom_range(0, 31) * 4);
            upd_taken_i   = ($urandom_range(0, 2) != 0);
            upd_target_i  = 9'($urandom_range(0, 127) * 4);
            cycle();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL random n=%0d: got %h exp %h", n, obs(), expv());
            end
        end
        idle();
        $display("test_random done: vectors=%0d", vectors);
    endtask

    initial begin
        m_pc = 0;
        m_cnt = 0;
        idle();
        test_reset();
        test_btb_train();
        test_counter_decay();
        test_stall();
        test_redirect_stall();
        test_alias();
        test_wrap_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
